// File: rtl/cpu_configuration.sv
// Shared front-end configuration: default address width, the RV32 opcodes
// that the pre-decoder recognises, PC generator states, and the layout of a
// fetched-instruction queue entry.
package cpu_configuration;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } pc_entry_t;

endpackage

// File: rtl/pc_queue.sv
// Small circular FIFO holding pre-decoded fetch entries for the decode stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (ignored when full or clearing)
//   pop         : drop the head entry (ignored when empty or clearing)
//   clear       : empty the queue; wins over a same-cycle push/pop
//   head        : entry at the head (content undefined while count is 0)
//   count       : number of stored entries, 0..QDEPTH
module pc_queue
  import cpu_configuration::*;
#(
  parameter int  QDEPTH  = 2,
  parameter type entry_t = pc_entry_t,
  localparam int CNT_W   = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             clear,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(QDEPTH - 1);

  entry_t           mem_r [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_en_s;
  logic             pop_en_s;

  // Pointer advance that also works when QDEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_C) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1'b1);
    end
    return r;
  endfunction

  // Qualified push/pop: clear cancels both, full/empty guard the storage.
  always_comb begin
    push_en_s = push && !clear && (count_r != DEPTH_C);
    pop_en_s  = pop  && !clear && (count_r != '0);
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_en_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/pc_gen_pred.sv
// Front-end PC generator with static branch prediction.
// Issues one fetch at a time, pre-decodes each returned instruction (JAL
// always taken; conditional branches backward-taken/forward-not-taken when
// BTFN_EN) and queues {pc, instr, prediction} for decode. The predicted
// target becomes the next fetch pc. An ALU redirect flushes the queue and
// any in-flight fetch.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   fetch_req_o / fetch_addr_o : fetch request and address (current pc)
//   fetch_gnt_i                : request accepted this cycle
//   instr_valid_i / instr_i    : fetch response
//   dec_valid_o / dec_ready_i  : queue head handshake towards decode
//   dec_pc_o, dec_instr_o,
//   dec_pred_taken_o,
//   dec_pred_target_o          : queue head contents, all 0 while empty
//   redirect_i / redirect_pc_i : flush and restart at redirect_pc_i
module pc_gen_pred
  import cpu_configuration::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QDEPTH       = 2,
  parameter bit              BTFN_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_addr_o,
  input  logic            fetch_gnt_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [31:0]     dec_instr_o,
  output logic            dec_pred_taken_o,
  output logic [XLEN-1:0] dec_pred_target_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  localparam int              CNT_W    = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);
  localparam logic [XLEN-1:0] INSTR_SZ = XLEN'(3'd4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } entry_t;

  pc_state_e        state_r;
  pc_state_e        state_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_nxt_s;
  logic             fetch_req_s;
  logic             push_s;
  logic             pop_s;
  logic             clear_s;
  logic [CNT_W-1:0] q_count_s;
  logic             q_valid_s;
  entry_t           head_s;
  entry_t           entry_s;
  logic [XLEN-1:0]  imm_j_s;
  logic [XLEN-1:0]  imm_b_s;
  logic             pred_taken_s;
  logic [XLEN-1:0]  pred_target_s;

  // Pre-decode of the returning instruction against the current pc.
  always_comb begin
    imm_j_s = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
               instr_i[20], instr_i[30:21], 1'b0};
    imm_b_s = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
               instr_i[30:25], instr_i[11:8], 1'b0};
    pred_taken_s  = 1'b0;
    pred_target_s = pc_r + INSTR_SZ;
    case (instr_i[6:0])
      OPC_JAL: begin
        pred_taken_s  = 1'b1;
        pred_target_s = pc_r + imm_j_s;
      end
      OPC_BRANCH: begin
        // Sign bit of the offset set means a backward branch.
        if (BTFN_EN && instr_i[31]) begin
          pred_taken_s  = 1'b1;
          pred_target_s = pc_r + imm_b_s;
        end else begin
          pred_taken_s  = 1'b0;
          pred_target_s = pc_r + INSTR_SZ;
        end
      end
      OPC_JALR: begin
        // Register-indirect target is unknown here: fall through.
        pred_taken_s  = 1'b0;
        pred_target_s = pc_r + INSTR_SZ;
      end
      default: begin
        pred_taken_s  = 1'b0;
        pred_target_s = pc_r + INSTR_SZ;
      end
    endcase
    entry_s.pc          = pc_r;
    entry_s.instr       = instr_i;
    entry_s.pred_taken  = pred_taken_s;
    entry_s.pred_target = pred_target_s;
  end

  // Next-state, next-pc, fetch request and queue control.
  always_comb begin
    state_s     = state_r;
    pc_nxt_s    = pc_r;
    fetch_req_s = 1'b0;
    push_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      BOOT: begin
        state_s = REQ;
      end
      REQ: begin
        if (redirect_i) begin
          clear_s  = 1'b1;
          pc_nxt_s = redirect_pc_i;
          state_s  = REQ;
        end else begin
          // Only request when a queue slot is guaranteed for the response.
          fetch_req_s = (q_count_s < DEPTH_C);
          if (fetch_req_s && fetch_gnt_i) begin
            state_s = WAIT;
          end else begin
            state_s = REQ;
          end
        end
      end
      WAIT: begin
        if (redirect_i) begin
          clear_s  = 1'b1;
          pc_nxt_s = redirect_pc_i;
          // A response landing with the redirect is simply dropped.
          if (instr_valid_i) begin
            state_s = REQ;
          end else begin
            state_s = DROP;
          end
        end else if (instr_valid_i) begin
          push_s   = 1'b1;
          pc_nxt_s = pred_target_s;
          state_s  = REQ;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (redirect_i) begin
          clear_s  = 1'b1;
          pc_nxt_s = redirect_pc_i;
          state_s  = DROP;
        end else if (instr_valid_i) begin
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // State and pc registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BOOT;
      pc_r    <= RESET_VECTOR;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_nxt_s;
    end
  end

  assign q_valid_s = (q_count_s != '0);
  assign pop_s     = q_valid_s && dec_ready_i;

  pc_queue #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .clear     (clear_s),
    .head      (head_s),
    .count     (q_count_s)
  );

  assign fetch_req_o       = fetch_req_s;
  assign fetch_addr_o      = pc_r;
  assign dec_valid_o       = q_valid_s;
  assign dec_pc_o          = q_valid_s ? head_s.pc          : '0;
  assign dec_instr_o       = q_valid_s ? head_s.instr       : '0;
  assign dec_pred_taken_o  = q_valid_s ? head_s.pred_taken  : 1'b0;
  assign dec_pred_target_o = q_valid_s ? head_s.pred_target : '0;

endmodule

// File: tb/tb_pc_gen_pred.sv
// Bench for pc_gen_pred: a fetch-level reference model (outstanding request,
// flushed-response flag, queue of predicted entries) checks every cycle;
// a vector table and hand-written sequences cover prediction cases,
// backpressure, redirects, pc wrap and reset. A second instance with
// BTFN_EN=0 shares all inputs and is checked on the table vectors.
module tb_pc_gen_pred;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam int          QD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
    logic        b_taken;
    logic [31:0] b_target;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req, fetch_gnt, instr_valid, dec_valid, dec_ready;
  logic        dec_taken, redirect;
  logic [31:0] fetch_addr, instr, dec_pc, dec_instr, dec_target, redirect_pc;
  logic        b_req, b_valid, b_taken;
  logic [31:0] b_addr, b_pc, b_instr, b_target;

  always #5 clk = ~clk;

  pc_gen_pred #(.XLEN(32), .RESET_VECTOR(RV), .QDEPTH(QD), .BTFN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_o(fetch_req), .fetch_addr_o(fetch_addr), .fetch_gnt_i(fetch_gnt),
    .instr_valid_i(instr_valid), .instr_i(instr),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .dec_pc_o(dec_pc),
    .dec_instr_o(dec_instr), .dec_pred_taken_o(dec_taken),
    .dec_pred_target_o(dec_target),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc));

  pc_gen_pred #(.XLEN(32), .RESET_VECTOR(RV), .QDEPTH(QD), .BTFN_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_o(b_req), .fetch_addr_o(b_addr), .fetch_gnt_i(fetch_gnt),
    .instr_valid_i(instr_valid), .instr_i(instr),
    .dec_valid_o(b_valid), .dec_ready_i(dec_ready), .dec_pc_o(b_pc),
    .dec_instr_o(b_instr), .dec_pred_taken_o(b_taken),
    .dec_pred_target_o(b_target),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc));

  int checks = 0;
  int errors = 0;

  // reference model
  bit   m_boot, m_out, m_stale;
  logic [31:0] m_pc;
  ent_t mq[$];

  // values sampled in the most recent cycle, before its clock edge
  logic        s_req, s_valid, s_taken, s_b_taken;
  logic [31:0] s_addr, s_pc, s_target, s_b_target;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Prediction from the instruction-set rules, using signed offsets.
  function automatic ent_t predict(input logic [31:0] pc, input logic [31:0] ins, input bit btfn);
    ent_t e;
    int   off;
    e.pc     = pc;
    e.instr  = ins;
    e.taken  = 1'b0;
    e.target = pc + 32'd4;
    if ((ins & 32'h7F) == 32'h6F) begin
      off = (ins[31] ? -1048576 : 0) + int'((ins >> 12) & 32'hFF) * 4096
          + int'((ins >> 20) & 32'h1) * 2048 + int'((ins >> 21) & 32'h3FF) * 2;
      e.taken  = 1'b1;
      e.target = pc + 32'(off);
    end else if ((ins & 32'h7F) == 32'h63) begin
      off = (ins[31] ? -4096 : 0) + int'((ins >> 7) & 32'h1) * 2048
          + int'((ins >> 25) & 32'h3F) * 32 + int'((ins >> 8) & 32'hF) * 2;
      if (btfn && off < 0) begin
        e.taken  = 1'b1;
        e.target = pc + 32'(off);
      end
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_boot  = 1'b1;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_pc    = RV;
    mq.delete();
  endfunction

  // One clock: drive at negedge, compare against the model, step at posedge.
  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit g,
                       input bit iv, input logic [31:0] ins, input bit rdy);
    bit   exp_req;
    ent_t h;
    redirect = rd; redirect_pc = rpc; fetch_gnt = g;
    instr_valid = iv; instr = ins; dec_ready = rdy;
    #1;
    exp_req = !m_boot && !m_out && (mq.size() < QD) && !rd;
    h = (mq.size() > 0) ? mq[0] : '0;
    s_req = fetch_req; s_addr = fetch_addr; s_valid = dec_valid;
    s_pc = dec_pc; s_taken = dec_taken; s_target = dec_target;
    s_b_taken = b_taken; s_b_target = b_target;
    check("fetch_req", fetch_req, exp_req);
    if (exp_req) check("fetch_addr", fetch_addr, m_pc);
    check("dec_valid", dec_valid, mq.size() != 0);
    check("dec_pc", dec_pc, h.pc);
    check("dec_instr", dec_instr, h.instr);
    check("dec_taken", dec_taken, h.taken);
    check("dec_target", dec_target, h.target);
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_pc = rpc;
      if (m_out && !m_stale) begin
        if (iv) m_out = 1'b0;
        else    m_stale = 1'b1;
      end
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (m_out) begin
        if (iv) begin
          if (!m_stale) begin
            mq.push_back(predict(m_pc, ins, 1'b1));
            m_pc = predict(m_pc, ins, 1'b1).target;
          end
          m_out   = 1'b0;
          m_stale = 1'b0;
        end
      end else if (exp_req && g) begin
        m_out = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Grant the next request (bounded wait), then return ins one cycle later.
  task automatic fetch_one(input logic [31:0] ins, input bit rdy);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, rdy);
      got = s_req;
    end
    check("fetch_wait", {31'h0, got}, 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, ins, rdy);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0:       return NOP;
      1:       return (r & 32'hFFFF_FF80) | 32'h6F;
      2, 3:    return (r & 32'hFFFF_FF80) | 32'h63;
      4:       return (r & 32'hFFFF_FF80) | 32'h67;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    else                           return $urandom() & 32'hFFFF_FFFC;
  endfunction

  initial begin
    bit          was_out, iv, rd;
    int          mem_delay;
    logic [31:0] rpc, ins;

    vecs[0] = '{32'h0000_0200, 32'hFF9F_F06F, 1'b1, 32'h0000_01F8, 1'b1, 32'h0000_01F8};
    vecs[1] = '{32'h0000_0300, 32'hFE00_08E3, 1'b1, 32'h0000_02F0, 1'b0, 32'h0000_0304};
    vecs[2] = '{32'h0000_0300, 32'h0000_0863, 1'b0, 32'h0000_0304, 1'b0, 32'h0000_0304};
    vecs[3] = '{32'h0000_0500, 32'h0080_006F, 1'b1, 32'h0000_0508, 1'b1, 32'h0000_0508};
    vecs[4] = '{32'h0000_0600, 32'h0000_8067, 1'b0, 32'h0000_0604, 1'b0, 32'h0000_0604};
    vecs[5] = '{32'hFFFF_FFFC, NOP,           1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h0000_0004, 32'hFF9F_F06F, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC};
    vecs[7] = '{32'h0000_0700, 32'h8000_0063, 1'b1, 32'hFFFF_F700, 1'b0, 32'h0000_0704};

    redirect = 1'b0; redirect_pc = 32'h0; fetch_gnt = 1'b0;
    instr_valid = 1'b0; instr = 32'h0; dec_ready = 1'b0;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_fetch_req", fetch_req, 32'h0);
    check("rst_dec_valid", dec_valid, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_target", dec_target, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("boot_no_req", s_req, 32'h0);

    // NOP stream from the reset vector
    fetch_one(NOP, 1'b0);
    check("nop_addr0", s_addr, RV);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("nop_addr1", s_addr, 32'h0000_0104);
    check("nop_head_pc", s_pc, 32'h0000_0100);
    check("nop_head_taken", s_taken, 32'h0);
    check("nop_head_target", s_target, 32'h0000_0104);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("nop_addr2", s_addr, 32'h0000_0108);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b1);
    drain();

    // prediction table
    for (int v = 0; v < 8; v++) begin
      cycle(1'b1, vecs[v].pc, 1'b0, 1'b0, 32'h0, 1'b1);
      fetch_one(vecs[v].instr, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("vec_valid", s_valid, 32'h1);
      check("vec_pc", s_pc, vecs[v].pc);
      check("vec_taken", s_taken, vecs[v].taken);
      check("vec_target", s_target, vecs[v].target);
      check("vec_next_addr", s_addr, vecs[v].target);
      check("vec_nb_taken", s_b_taken, vecs[v].b_taken);
      check("vec_nb_target", s_b_target, vecs[v].b_target);
      drain();
    end

    // backpressure: full queue blocks requests, one pop frees one request
    cycle(1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0, 1'b1);
    fetch_one(NOP, 1'b0);
    fetch_one(NOP, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("full_no_req", s_req, 32'h0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("full_pop_head", s_pc, 32'h0000_0800);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_one_req", s_req, 32'h1);
    check("bp_one_addr", s_addr, 32'h0000_0808);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_wait_no_req", s_req, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, NOP, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_full_again", s_req, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("fifo_order0", s_pc, 32'h0000_0804);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("fifo_order1", s_pc, 32'h0000_0808);
    drain();

    // redirect while waiting, late response dropped
    cycle(1'b1, 32'h0000_0900, 1'b0, 1'b0, 32'h0, 1'b1);
    fetch_one(NOP, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("rd_granted", s_req, 32'h1);
    cycle(1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rd_cycle_valid", s_valid, 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b0);
    check("rd_flushed", s_valid, 32'h0);
    check("rd_drop_no_req", s_req, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("rd_late_dropped", s_valid, 32'h0);
    check("rd_new_addr", s_addr, 32'h0000_0400);
    // redirect coincident with the response
    cycle(1'b1, 32'h0000_0400, 1'b0, 1'b1, NOP, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rdc_no_push", s_valid, 32'h0);
    check("rdc_req", s_req, 32'h1);
    check("rdc_addr", s_addr, 32'h0000_0400);

    // asynchronous reset while waiting
    fetch_one(NOP, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("ar_granted", s_req, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar_req", fetch_req, 32'h0);
    check("ar_valid", dec_valid, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b1; instr = NOP;
    #1;
    check("ar_stray_valid", dec_valid, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b0);
    check("ar_boot_req", s_req, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b0);
    check("ar_first_req", s_req, 32'h1);
    check("ar_first_addr", s_addr, RV);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ar_stray_ignored", s_valid, 32'h0);

    // randomized traffic against the model
    mem_delay = 0;
    for (int n = 0; n < 4000; n++) begin
      iv  = m_out && (mem_delay == 0);
      rd  = ($urandom_range(0, 24) == 0) && !(m_stale && iv);
      rpc = rand_pc();
      ins = rand_instr();
      was_out = m_out;
      cycle(rd, rpc, bit'($urandom_range(0, 1)), iv, ins, $urandom_range(0, 2) != 0);
      if (!was_out && m_out) mem_delay = $urandom_range(0, 2);
      else if (m_out && mem_delay > 0) mem_delay--;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
